// File: rtl/cache_refill_unit.sv
// Miss/refill engine: writes back a dirty victim line, reads the missing line beat by beat, returns it as one fill.
// Build option CACHE_REFILL_CRITICAL_WORD_FIRST_EN: read burst starts at the missing word and wraps.
module cache_refill_unit #(
    parameter int WIDTH         = 64,
    parameter int LOGLINEOFFSET = 3,
    parameter int ADDRW         = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              miss_valid,
    output logic                              miss_ready,
    input  logic [ADDRW-1:0]                  miss_addr,
    input  logic                              victim_dirty,
    input  logic [ADDRW-1:0]                  victim_addr,
    input  logic [(WIDTH<<LOGLINEOFFSET)-1:0] victim_line,
    output logic                              bus_req_valid,
    input  logic                              bus_req_ready,
    output logic                              bus_req_write,
    output logic [ADDRW-1:0]                  bus_req_addr,
    output logic [WIDTH-1:0]                  bus_req_data,
    input  logic                              bus_resp_valid,
    input  logic [WIDTH-1:0]                  bus_resp_data,
    output logic                              fill_valid,
    input  logic                              fill_ready,
    output logic [ADDRW-1:0]                  fill_addr,
    output logic [(WIDTH<<LOGLINEOFFSET)-1:0] fill_line,
    output logic                              crit_valid,
    output logic [WIDTH-1:0]                  crit_data,
    output logic                              err_resp
);
    localparam int WORDS = 1 << LOGLINEOFFSET;
    localparam int LINEW = WIDTH << LOGLINEOFFSET;
    localparam logic [ADDRW-1:0] OFFMASK = ADDRW'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL} stateT;

    stateT                    stateReg, stateNext;
    logic [LOGLINEOFFSET-1:0] cntReg, cntNext;
    logic [ADDRW-1:0]         missAddrReg, victimAddrReg;
    logic [LINEW-1:0]         victimLineReg;
    logic                     critValidReg, errReg;
    logic [WIDTH-1:0]         critDataReg;

    logic                     captureMiss, storeBeat, critHit, fillValid;
    logic [LOGLINEOFFSET-1:0] missOff, baseOff, slot;
    logic [ADDRW-1:0]         missLineAddr, victimLineAddr, readAddr;
    logic [LINEW-1:0]         lineBuf;

    assign missOff        = missAddrReg[LOGLINEOFFSET-1:0];
    assign missLineAddr   = missAddrReg & ~OFFMASK;
    assign victimLineAddr = victimAddrReg & ~OFFMASK;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    // Memory answers a word-addressed read in wrapping order starting at that word.
    assign baseOff  = missOff;
    assign readAddr = missAddrReg;
`else
    assign baseOff  = '0;
    assign readAddr = missLineAddr;
`endif

    assign slot      = cntReg + baseOff;
    assign storeBeat = (stateReg == RD_DATA) && bus_resp_valid;
    assign critHit   = storeBeat && (slot == missOff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg      <= IDLE;
            cntReg        <= '0;
            missAddrReg   <= '0;
            victimAddrReg <= '0;
            victimLineReg <= '0;
            critValidReg  <= 1'b0;
            critDataReg   <= '0;
            errReg        <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            critValidReg <= critHit;
            if (captureMiss) begin
                missAddrReg   <= miss_addr;
                victimAddrReg <= victim_addr;
                victimLineReg <= victim_line;
            end
            if (critHit) begin
                critDataReg <= bus_resp_data;
            end
            // Beats arriving outside the read burst are dropped but remembered.
            if (bus_resp_valid && (stateReg != RD_DATA)) begin
                errReg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : gWord
            logic [WIDTH-1:0] wordReg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wordReg <= '0;
                end else if (storeBeat && (slot == LOGLINEOFFSET'(gi))) begin
                    wordReg <= bus_resp_data;
                end
            end
            assign lineBuf[gi*WIDTH +: WIDTH] = wordReg;
        end
    endgenerate

    always_comb begin
        stateNext     = stateReg;
        cntNext       = cntReg;
        captureMiss   = 1'b0;
        bus_req_valid = 1'b0;
        bus_req_write = 1'b0;
        bus_req_addr  = '0;
        bus_req_data  = '0;
        fillValid     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (miss_valid) begin
                    captureMiss = 1'b1;
                    stateNext   = victim_dirty ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: begin
                bus_req_valid = 1'b1;
                bus_req_write = 1'b1;
                bus_req_addr  = victimLineAddr;
                if (bus_req_ready) begin
                    stateNext = WB_DATA;
                    cntNext   = '0;
                end
            end
            WB_DATA: begin
                bus_req_valid = 1'b1;
                bus_req_data  = victimLineReg[int'(cntReg)*WIDTH +: WIDTH];
                if (bus_req_ready) begin
                    cntNext = cntReg + 1'b1;
                    if (&cntReg) begin
                        stateNext = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                bus_req_valid = 1'b1;
                bus_req_addr  = readAddr;
                if (bus_req_ready) begin
                    stateNext = RD_DATA;
                    cntNext   = '0;
                end
            end
            RD_DATA: begin
                if (bus_resp_valid) begin
                    cntNext = cntReg + 1'b1;
                    if (&cntReg) begin
                        stateNext = FILL;
                    end
                end
            end
            FILL: begin
                fillValid = 1'b1;
                if (fill_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Gated by rst_n so every output reads 0 while reset is held.
    assign miss_ready = rst_n && (stateReg == IDLE);
    assign fill_valid = fillValid;
    assign fill_addr  = fillValid ? missLineAddr : '0;
    assign fill_line  = fillValid ? lineBuf : '0;
    assign crit_valid = critValidReg;
    assign crit_data  = critDataReg;
    assign err_resp   = errReg;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed bench for cache_refill_unit: table of clean misses plus writeback, backpressure and reset sequences.
module tb_cache_refill_unit;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_valid, miss_ready, victim_dirty;
    logic [63:0]  miss_addr, victim_addr;
    logic [511:0] victim_line;
    logic         bus_req_valid, bus_req_ready, bus_req_write;
    logic [63:0]  bus_req_addr, bus_req_data;
    logic         bus_resp_valid;
    logic [63:0]  bus_resp_data;
    logic         fill_valid, fill_ready;
    logic [63:0]  fill_addr;
    logic [511:0] fill_line;
    logic         crit_valid, err_resp;
    logic [63:0]  crit_data;

    int compared   = 0;
    int mismatched = 0;

    cache_refill_unit dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
        .bus_req_addr(bus_req_addr), .bus_req_data(bus_req_data),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_line(fill_line),
        .crit_valid(crit_valid), .crit_data(crit_data), .err_resp(err_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] respBase;
        logic [63:0] expReq;
        logic [63:0] expFill;
        int          startOff;
        int          critOff;
        logic [63:0] expCrit;
    } vecT;

    vecT vecs[4];

    task automatic check1(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic checkLine(input string name, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check1({tag, "_miss_ready"}, miss_ready, 1'b0);
        check1({tag, "_req_valid"}, bus_req_valid, 1'b0);
        check1({tag, "_req_write"}, bus_req_write, 1'b0);
        check64({tag, "_req_addr"}, bus_req_addr, 64'h0);
        check64({tag, "_req_data"}, bus_req_data, 64'h0);
        check1({tag, "_fill_valid"}, fill_valid, 1'b0);
        check64({tag, "_fill_addr"}, fill_addr, 64'h0);
        checkLine({tag, "_fill_line"}, fill_line, 512'h0);
        check1({tag, "_crit_valid"}, crit_valid, 1'b0);
        check64({tag, "_crit_data"}, crit_data, 64'h0);
        check1({tag, "_err_resp"}, err_resp, 1'b0);
    endtask

    // Called just after a negedge in IDLE; returns just after the negedge where the miss was taken.
    task automatic issueMiss(input logic [63:0] addr, input logic dirty, input logic [63:0] vaddr);
        check1("miss_ready_idle", miss_ready, 1'b1);
        miss_valid   = 1'b1;
        miss_addr    = addr;
        victim_dirty = dirty;
        victim_addr  = vaddr;
        @(negedge clk);
        miss_valid   = 1'b0;
        victim_dirty = 1'b0;
    endtask

    task automatic readReq(input logic [63:0] expAddr);
        check1("rd_req_valid", bus_req_valid, 1'b1);
        check1("rd_req_write", bus_req_write, 1'b0);
        check64("rd_req_addr", bus_req_addr, expAddr);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
    endtask

    // Word w of the memory line holds base+w; beat i carries word (startOff+i) mod 8.
    task automatic doRead(input logic [63:0] base, input int startOff, input int critOff,
                          input logic [63:0] expFill, input logic [63:0] expCrit, input int stall);
        logic [511:0] expLine;
        for (int w = 0; w < 8; w++) expLine[w*64 +: 64] = base + 64'(w);
        for (int i = 0; i < 8; i++) begin
            int w;
            w = (startOff + i) % 8;
            bus_resp_valid = 1'b1;
            bus_resp_data  = base + 64'(w);
            @(negedge clk);
            bus_resp_valid = 1'b0;
            check1("crit_valid_beat", crit_valid, w == critOff);
        end
        check1("fill_valid", fill_valid, 1'b1);
        check64("fill_addr", fill_addr, expFill);
        checkLine("fill_line", fill_line, expLine);
        check64("crit_data", crit_data, expCrit);
        check1("miss_ready_fill", miss_ready, 1'b0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check1("fill_hold_valid", fill_valid, 1'b1);
            checkLine("fill_hold_line", fill_line, expLine);
            check64("fill_hold_addr", fill_addr, expFill);
            check1("fill_hold_miss_ready", miss_ready, 1'b0);
        end
        fill_ready = 1'b1;
        @(negedge clk);
        fill_ready = 1'b0;
        check1("fill_done", fill_valid, 1'b0);
        check1("miss_ready_after", miss_ready, 1'b1);
        $display("fill addr=%0h crit=%0h done", expFill, expCrit);
    endtask

    task automatic runClean(input vecT v);
        issueMiss(v.addr, 1'b0, 64'h0);
        readReq(v.expReq);
        doRead(v.respBase, v.startOff, v.critOff, v.expFill, v.expCrit, 0);
        check1("err_clean", err_resp, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        miss_valid = 1'b0; miss_addr = '0; victim_dirty = 1'b0; victim_addr = '0; victim_line = '0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0; fill_ready = 1'b0;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        vecs[0] = '{64'h1234, 64'hA0, 64'h1234, 64'h1230, 4, 4, 64'hA4};
        vecs[1] = '{64'h0, 64'h10, 64'h0, 64'h0, 0, 0, 64'h10};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h50, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF8, 7, 7, 64'h57};
        vecs[3] = '{64'h1235, 64'hB0, 64'h1235, 64'h1230, 5, 5, 64'hB5};
`else
        vecs[0] = '{64'h1234, 64'hA0, 64'h1230, 64'h1230, 0, 4, 64'hA4};
        vecs[1] = '{64'h0, 64'h10, 64'h0, 64'h0, 0, 0, 64'h10};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h50, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 0, 7, 64'h57};
        vecs[3] = '{64'h1235, 64'hB0, 64'h1230, 64'h1230, 0, 5, 64'hB5};
`endif
        for (int i = 0; i < 8; i++) victim_line[i*64 +: 64] = 64'hD0 + 64'(i);

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) runClean(vecs[v]);

        // Dirty miss with a 5-cycle stall on writeback beat 3, then a fill held off while a second miss waits.
        issueMiss(64'h40, 1'b1, 64'h8B);
        check1("wb_req_valid", bus_req_valid, 1'b1);
        check1("wb_req_write", bus_req_write, 1'b1);
        check64("wb_req_addr", bus_req_addr, 64'h88);
        bus_req_ready = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                bus_req_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check1("wb_hold_valid", bus_req_valid, 1'b1);
                    check64("wb_hold_data", bus_req_data, 64'hD3);
                end
                bus_req_ready = 1'b1;
            end
            check1("wb_data_valid", bus_req_valid, 1'b1);
            check64("wb_data", bus_req_data, 64'hD0 + 64'(b));
            @(negedge clk);
            $display("writeback beat %0d data=%0h", b, 64'hD0 + 64'(b));
        end
        bus_req_ready = 1'b0;
        readReq(64'h40);
        miss_valid = 1'b1;
        miss_addr  = 64'h3000;
        doRead(64'h60, 0, 0, 64'h40, 64'h60, 4);
        @(negedge clk);
        miss_valid = 1'b0;
        readReq(64'h3000);
        doRead(64'h70, 0, 0, 64'h3000, 64'h70, 0);

        // Reset in the middle of the read burst, on beat 4.
        issueMiss(64'h1234, 1'b0, 64'h0);
        readReq(vecs[0].expReq);
        for (int i = 0; i < 4; i++) begin
            bus_resp_valid = 1'b1;
            bus_resp_data  = 64'hE0 + 64'(i);
            @(negedge clk);
        end
        bus_resp_data = 64'hE4;
        #2 rst_n = 1'b0;
        #1 checkAllZero("midreset");
        @(negedge clk);
        bus_resp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runClean('{64'h1234, 64'hC0, vecs[0].expReq, 64'h1230, vecs[0].startOff, 4, 64'hC4});

        // Stray response in IDLE sets the sticky error.
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'hEE;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        check1("err_stray", err_resp, 1'b1);
        check1("stray_idle", miss_ready, 1'b1);
        repeat (2) @(negedge clk);
        check1("err_sticky", err_resp, 1'b1);
        $display("stray response err_resp=%0b", err_resp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
